net_tx_sched: RTL and testbench

NET_TX_SCHED -- requirements
Module: net_tx_sched

---
 rtl/net_pkg.sv | 41 ++++
 rtl/net_link_wd.sv | 49 ++++
 rtl/net_tx_sched.sv | 159 +++++++++++++++
 tb/tb_net_tx_sched.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/net_pkg.sv
// rtl/net_pkg.sv - scheduler states, payload bit layout and payload packing shared by net transmit/receive
package net_pkg;

  localparam int PAYLOAD_W = 44;

  localparam int X_LSB    = 33;
  localparam int X_W      = 11;
  localparam int Y_LSB    = 21;
  localparam int Y_W      = 11;
  localparam int DIR_LSB  = 11;
  localparam int DIR_W    = 9;
  localparam int GAME_LSB = 5;
  localparam int GAME_W   = 3;
  localparam int RST_BIT  = 3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_REQ       = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_GAP       = 2'd3
  } net_state_e;

  // Unused payload bits stay zero so the receiver can treat them as reserved.
  function automatic logic [PAYLOAD_W-1:0] pack_payload(
    input logic [X_W-1:0]    x,
    input logic [Y_W-1:0]    y,
    input logic [DIR_W-1:0]  dir,
    input logic [GAME_W-1:0] game,
    input logic              rst_flag
  );
    logic [PAYLOAD_W-1:0] p;
    p                        = '0;
    p[X_LSB +: X_W]          = x;
    p[Y_LSB +: Y_W]          = y;
    p[DIR_LSB +: DIR_W]      = dir;
    p[GAME_LSB +: GAME_W]    = game;
    p[RST_BIT]               = rst_flag;
    return p;
  endfunction

endpackage

// File: rtl/net_link_wd.sv
// rtl/net_link_wd.sv - link watchdog: drops link_up after LINK_FRAMES frames with no received packet
module net_link_wd
  import net_pkg::*;
#(
  parameter int LINK_FRAMES = 30
) (
  input  logic clk,
  input  logic rst,
  input  logic vsync_edge,
  input  logic rx_valid,
  output logic link_up
);

  localparam int FC_W = $clog2(LINK_FRAMES + 1);

  logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
  logic            link_up_q, link_up_d;

  // A received packet revives the link; frames without one count toward timeout (counter saturates).
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    link_up_d   = link_up_q;
    if (rx_valid) begin
      frame_cnt_d = '0;
      link_up_d   = 1'b1;
    end else if (vsync_edge) begin
      if (frame_cnt_q != FC_W'(LINK_FRAMES)) begin
        frame_cnt_d = frame_cnt_q + FC_W'(1);
      end
      if (frame_cnt_d == FC_W'(LINK_FRAMES)) begin
        link_up_d = 1'b0;
      end
    end
  end

  // Watchdog state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
      link_up_q   <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      link_up_q   <= link_up_d;
    end
  end

  assign link_up = link_up_q;

endmodule

// File: rtl/net_tx_sched.sv
// rtl/net_tx_sched.sv - paces frame/reset packet requests to the transmitter; link watchdog under NET_LINK_WATCHDOG_EN
module net_tx_sched
  import net_pkg::*;
#(
  parameter int GAP_CYCLES   = 64,
  parameter int DONE_TIMEOUT = 4096,
  parameter int LINK_FRAMES  = 30
) (
  input  logic        eth_refclk,
  input  logic        eth_rst,
  input  logic        vsync_in,
  input  logic [10:0] player_x,
  input  logic [10:0] player_y,
  input  logic [8:0]  direction,
  input  logic [2:0]  game_stat,
  input  logic        reset_req,
  input  logic        tx_ready,
  input  logic        tx_done,
  input  logic        rx_valid,
  output logic        tx_valid,
  output logic [43:0] tx_data,
  output logic        busy,
  output logic        link_up,
  output logic [7:0]  drop_cnt
);

  localparam int CNT_MAX = (DONE_TIMEOUT > GAP_CYCLES) ? DONE_TIMEOUT : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  net_state_e           state_q, state_d;
  logic                 tx_valid_q, tx_valid_d;
  logic [PAYLOAD_W-1:0] tx_data_q, tx_data_d;
  logic                 busy_q, busy_d;
  logic [7:0]           drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 frame_pend_q, frame_pend_d;
  logic                 reset_pend_q, reset_pend_d;
  logic                 serve_reset_q, serve_reset_d;
  logic                 vsync_prev_q, vsync_prev_d;

  logic vsync_edge, frame_any, reset_any, clr_frame, clr_reset;

  // Next-state logic: events seen this cycle count as pending so IDLE can launch without an extra cycle.
  always_comb begin
    vsync_edge    = vsync_in & ~vsync_prev_q;
    frame_any     = frame_pend_q | vsync_edge;
    reset_any     = reset_pend_q | reset_req;
    state_d       = state_q;
    tx_valid_d    = tx_valid_q;
    tx_data_d     = tx_data_q;
    drop_cnt_d    = drop_cnt_q;
    cnt_d         = cnt_q;
    serve_reset_d = serve_reset_q;
    clr_frame     = 1'b0;
    clr_reset     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (frame_any | reset_any) begin
          state_d       = ST_REQ;
          tx_valid_d    = 1'b1;
          serve_reset_d = reset_any;
          tx_data_d     = pack_payload(player_x, player_y, direction, game_stat, reset_any);
        end
      end
      ST_REQ: begin
        if (tx_valid_q & tx_ready) begin
          // Any accepted packet satisfies the frame request; a reset packet also consumes the reset request.
          state_d    = ST_WAIT_DONE;
          tx_valid_d = 1'b0;
          cnt_d      = '0;
          clr_frame  = 1'b1;
          clr_reset  = serve_reset_q;
        end
      end
      ST_WAIT_DONE: begin
        if (tx_done) begin
          state_d = ST_GAP;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(DONE_TIMEOUT - 1)) begin
          state_d = ST_GAP;
          cnt_d   = '0;
          if (drop_cnt_q != 8'hFF) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // New events win over a same-cycle clear so a request arriving at handshake is not lost.
    frame_pend_d = (frame_pend_q & ~clr_frame) | vsync_edge;
    reset_pend_d = (reset_pend_q & ~clr_reset) | reset_req;
    busy_d       = (state_d != ST_IDLE);
    vsync_prev_d = vsync_in;
  end

  // Scheduler FSM and its registered outputs.
  always_ff @(posedge eth_refclk) begin
    if (eth_rst) begin
      state_q       <= ST_IDLE;
      tx_valid_q    <= 1'b0;
      tx_data_q     <= '0;
      busy_q        <= 1'b0;
      drop_cnt_q    <= 8'd0;
      cnt_q         <= '0;
      frame_pend_q  <= 1'b0;
      reset_pend_q  <= 1'b0;
      serve_reset_q <= 1'b0;
      vsync_prev_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      tx_valid_q    <= tx_valid_d;
      tx_data_q     <= tx_data_d;
      busy_q        <= busy_d;
      drop_cnt_q    <= drop_cnt_d;
      cnt_q         <= cnt_d;
      frame_pend_q  <= frame_pend_d;
      reset_pend_q  <= reset_pend_d;
      serve_reset_q <= serve_reset_d;
      vsync_prev_q  <= vsync_prev_d;
    end
  end

  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign busy     = busy_q;
  assign drop_cnt = drop_cnt_q;

`ifdef NET_LINK_WATCHDOG_EN
  net_link_wd #(
    .LINK_FRAMES(LINK_FRAMES)
  ) u_link_wd (
    .clk       (eth_refclk),
    .rst       (eth_rst),
    .vsync_edge(vsync_edge),
    .rx_valid  (rx_valid),
    .link_up   (link_up)
  );
`else
  // Without the watchdog the link is assumed always up and receive activity is ignored.
  localparam int unused_link_frames = LINK_FRAMES;
  logic unused_rx;
  assign unused_rx = rx_valid;
  assign link_up   = 1'b1;
`endif

endmodule

// File: tb/tb_net_tx_sched.sv
// tb/tb_net_tx_sched.sv - randomized self-checking bench for net_tx_sched against a timeline model
module tb_net_tx_sched;

  localparam int GAP = 8;
  localparam int DTO = 16;
  localparam int LF  = 3;

  logic        eth_refclk = 1'b0;
  logic        eth_rst, vsync_in, reset_req, tx_ready, tx_done, rx_valid;
  logic [10:0] player_x, player_y;
  logic [8:0]  direction;
  logic [2:0]  game_stat;
  logic        tx_valid, busy, link_up;
  logic [43:0] tx_data;
  logic [7:0]  drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 eth_refclk = ~eth_refclk;

  net_tx_sched #(
    .GAP_CYCLES  (GAP),
    .DONE_TIMEOUT(DTO),
    .LINK_FRAMES (LF)
  ) dut (
    .eth_refclk(eth_refclk),
    .eth_rst   (eth_rst),
    .vsync_in  (vsync_in),
    .player_x  (player_x),
    .player_y  (player_y),
    .direction (direction),
    .game_stat (game_stat),
    .reset_req (reset_req),
    .tx_ready  (tx_ready),
    .tx_done   (tx_done),
    .rx_valid  (rx_valid),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .busy      (busy),
    .link_up   (link_up),
    .drop_cnt  (drop_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [43:0] pack(input int x, input int y, input int d, input int g, input bit r);
    logic [63:0] v;
    v = (64'(x) << 33) | (64'(y) << 21) | (64'(d) << 11) | (64'(g) << 5) | (64'(r) << 3);
    return v[43:0];
  endfunction

`ifdef NET_LINK_WATCHDOG_EN
  localparam bit LINK_AT_RESET = 1'b0;
`else
  localparam bit LINK_AT_RESET = 1'b1;
`endif

  // Timeline model: a packet is on offer, awaiting done since a cycle, or resting until a cycle.
  int          cyc = 0;
  bit          model_on = 0;
  bit          m_prev_v, m_want_frame, m_want_reset, m_offer, m_serve_reset;
  int          m_await_since = -1;
  int          m_rest_until  = -1;
  bit          m_valid, m_busy, m_link;
  logic [43:0] m_data;
  int          m_drops, m_frames;
  bit          ev_edge, ev_hs, last_valid;
  int          rises = 0;

  always @(posedge eth_refclk) begin
    cyc++;
    ev_edge = vsync_in && !m_prev_v;
    if (eth_rst) begin
      model_on      = 1;
      m_want_frame  = 0;
      m_want_reset  = 0;
      m_offer       = 0;
      m_serve_reset = 0;
      m_await_since = -1;
      m_rest_until  = -1;
      m_valid       = 0;
      m_data        = '0;
      m_busy        = 0;
      m_drops       = 0;
      m_frames      = 0;
      m_link        = LINK_AT_RESET;
      m_prev_v      = 0;
    end else begin
      ev_hs = 0;
      if (m_offer) begin
        if (tx_ready) begin
          ev_hs         = 1;
          m_offer       = 0;
          m_valid       = 0;
          m_await_since = cyc;
        end
      end else if (m_await_since >= 0) begin
        if (tx_done || (cyc - m_await_since) == DTO) begin
          if (!tx_done && m_drops < 255) m_drops++;
          m_await_since = -1;
          m_rest_until  = cyc + GAP;
        end
      end else if (m_rest_until >= 0) begin
        if (cyc == m_rest_until) m_rest_until = -1;
      end else if (m_want_frame || m_want_reset || ev_edge || reset_req) begin
        m_offer       = 1;
        m_valid       = 1;
        m_serve_reset = m_want_reset || reset_req;
        m_data        = pack(player_x, player_y, direction, game_stat, m_serve_reset);
      end
      if (ev_hs) begin
        m_want_frame = 0;
        if (m_serve_reset) m_want_reset = 0;
      end
      if (ev_edge)   m_want_frame = 1;
      if (reset_req) m_want_reset = 1;
`ifdef NET_LINK_WATCHDOG_EN
      if (rx_valid) begin
        m_link   = 1;
        m_frames = 0;
      end else if (ev_edge) begin
        if (m_frames < LF) m_frames++;
        if (m_frames >= LF) m_link = 0;
      end
`endif
      m_busy   = m_offer || (m_await_since >= 0) || (m_rest_until >= 0);
      m_prev_v = vsync_in;
    end
    #1;
    if (model_on) begin
      check("tx_valid", tx_valid, m_valid);
      check("tx_data",  tx_data,  m_data);
      check("busy",     busy,     m_busy);
      check("drop_cnt", drop_cnt, m_drops);
      check("link_up",  link_up,  m_link);
    end
    if (tx_valid && !last_valid) rises++;
    last_valid = tx_valid;
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge eth_refclk);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 300) begin
      step();
      k++;
    end
    check("idle_reached", busy, 1'b0);
  endtask

  task automatic done_pulse();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
  endtask

  initial begin
    int r0;
    logic [43:0] held;
    eth_rst   = 1'b1;
    vsync_in  = 1'b0;
    reset_req = 1'b0;
    tx_ready  = 1'b0;
    tx_done   = 1'b0;
    rx_valid  = 1'b0;
    player_x  = '0;
    player_y  = '0;
    direction = '0;
    game_stat = '0;
    step(3);

    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_data",  tx_data,  44'h0);
    check("rst_busy",     busy,     1'b0);
    check("rst_drop_cnt", drop_cnt, 8'd0);
    check("rst_link_up",  link_up,  LINK_AT_RESET);
    eth_rst = 1'b0;
    step(2);

    // Frame packet with the reference payload.
    player_x  = 11'd191;
    player_y  = 11'd191;
    direction = 9'd270;
    game_stat = 3'd1;
    vsync_in  = 1'b1;
    tx_ready  = 1'b1;
    step();
    vsync_in  = 1'b0;
    check("t1_valid_next", tx_valid, 1'b1);
    check("t1_data",       tx_data,  44'h17E_17E8_7020);
    check("t1_rst_bit",    tx_data[3], 1'b0);
    step();
    check("t1_valid_drop", tx_valid, 1'b0);
    tx_ready = 1'b0;
    done_pulse();
    wait_idle();

    // Back-pressure: request held stable while payload inputs change.
    player_x  = 11'd5;
    player_y  = 11'd1000;
    direction = 9'd359;
    game_stat = 3'd6;
    held      = pack(5, 1000, 359, 6, 1'b0);
    vsync_in  = 1'b1;
    step();
    vsync_in  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      check("t2_valid_held", tx_valid, 1'b1);
      check("t2_data_held",  tx_data,  held);
      player_x  = 11'($urandom);
      player_y  = 11'($urandom);
      direction = 9'($urandom);
      game_stat = 3'($urandom);
      step();
    end
    tx_ready = 1'b1;
    step();
    check("t2_valid_after_hs", tx_valid, 1'b0);
    tx_ready = 1'b0;
    done_pulse();
    wait_idle();

    // Reset request and vsync together: one reset packet only.
    vsync_in  = 1'b1;
    reset_req = 1'b1;
    step();
    reset_req = 1'b0;
    vsync_in  = 1'b0;
    check("t3_valid",   tx_valid,   1'b1);
    check("t3_rst_bit", tx_data[3], 1'b1);
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    done_pulse();
    wait_idle();
    r0 = rises;
    step(12);
    check("t3_no_frame_pkt", rises - r0, 0);
    check("t3_still_idle",   busy, 1'b0);

    // Done never arrives: timeout after DTO cycles bumps drop_cnt.
    check("t4_drop_before", drop_cnt, 8'd0);
    vsync_in = 1'b1;
    tx_ready = 1'b1;
    step(2);
    tx_ready = 1'b0;
    vsync_in = 1'b0;
    step(DTO - 1);
    check("t4_drop_early", drop_cnt, 8'd0);
    check("t4_busy_wait",  busy, 1'b1);
    step();
    check("t4_drop_one",   drop_cnt, 8'd1);
    check("t4_busy_gap",   busy, 1'b1);
    wait_idle();
    check("t4_drop_kept",  drop_cnt, 8'd1);

    // Three vsync edges while busy coalesce into one further packet.
    r0       = rises;
    vsync_in = 1'b1;
    tx_ready = 1'b1;
    step(2);
    repeat (3) begin
      vsync_in = 1'b0;
      step();
      vsync_in = 1'b1;
      step();
    end
    vsync_in = 1'b0;
    done_pulse();
    wait_idle();
    step(2);
    done_pulse();
    wait_idle();
    step(4);
    check("t5_two_packets", rises - r0, 2);
    tx_ready = 1'b0;

    // Link watchdog.
`ifdef NET_LINK_WATCHDOG_EN
    check("t6_link_down_init", link_up, 1'b0);
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    check("t6_link_up_rx", link_up, 1'b1);
    for (int k = 0; k < 3; k++) begin
      vsync_in = 1'b1;
      step();
      vsync_in = 1'b0;
      step();
      check("t6_link_frames", link_up, (k < 2) ? 1'b1 : 1'b0);
    end
`else
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    vsync_in = 1'b1;
    step();
    vsync_in = 1'b0;
    check("t6_link_tied", link_up, 1'b1);
`endif

    // Randomized traffic including mid-packet resets.
    for (int i = 0; i < 3000; i++) begin
      eth_rst   = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 5) == 0) vsync_in = ~vsync_in;
      reset_req = ($urandom_range(0, 39) == 0);
      tx_ready  = $urandom_range(0, 1);
      tx_done   = ($urandom_range(0, 9) == 0);
      rx_valid  = ($urandom_range(0, 49) == 0);
      player_x  = 11'($urandom);
      player_y  = 11'($urandom);
      direction = 9'($urandom);
      game_stat = 3'($urandom);
      step();
    end

    // drop_cnt saturation: every packet times out.
    eth_rst   = 1'b1;
    reset_req = 1'b0;
    rx_valid  = 1'b0;
    tx_done   = 1'b0;
    step();
    eth_rst  = 1'b0;
    tx_ready = 1'b1;
    for (int i = 0; i < 7500; i++) begin
      if (i % 4 == 0) vsync_in = ~vsync_in;
      step();
    end
    check("drop_saturated", drop_cnt, 8'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
